multiport_register_file: RTL
============================

Name: multiport_register_file

Overview:
- Parametrised successor to the fixed 8-read/2-write integer register file of the superscalar MIPS core.
- Generalised data width, register count, read-port count and write-port count.
- Adds asynchronous reset of the storage array.
- Adds a per-register busy scoreboard. Issue sets a register's busy bit through reserve ports; writeback clears it.
- Sits between decode/issue (reads, reserves) and writeback (writes).

Parameters:
- DW, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero
- NRD, 8, number of read ports
- NWR, 2, number of write ports
- NRSV, 2, number of reserve (busy-set) ports
- AW, $clog2(NREG), address width (derived; do not override)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- RA  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
- RD  out  NRD*DW  read data; port i at bits [i*DW +: DW]
- RBUSY  out  NRD  busy status of the register addressed by each read port
- WE  in  NWR  write enables
- WA  in  NWR*AW  write addresses
- WD  in  NWR*DW  write data
- RSV_EN  in  NRSV  reserve enables
- RSV_A  in  NRSV*AW  reserve addresses

Behaviour:
- Reset (async assert, sync-safe release): every register clears to 0 and every busy bit clears to 0. Reset asserted mid-operation discards all same-cycle writes and reserves. While RST=1, RD outputs 0 and RBUSY outputs 0.
- Read: combinational, zero latency. RD[i] = 0 and RBUSY[i] = 0 whenever RA[i] = 0.
- Write: on a clock edge with WE[j]=1 and WA[j]!=0, reg[WA[j]] <= WD[j]. Writes to register 0 are ignored.
- Write conflict: when two write ports target the same address in one cycle, the highest-index port wins. The same priority applies to storage and to bypass.
- Busy update per register r, per edge:
  - set if any RSV_EN[k] has RSV_A[k]=r;
  - else clear if any WE[j] has WA[j]=r;
  - else hold.
  - Reserve beats writeback because the new producer supersedes the old one.
  - Register 0 never becomes busy.
- Busy-bit contract: a writeback to a register that is not busy still updates data; this is not an error. Reserving a register that is already busy keeps it busy.
- RBUSY is the registered busy bit, modified as follows with the bypass feature. There is no stall logic inside the block; the issue stage consumes RBUSY.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - RD[i] returns the same-cycle WD of the highest-index write port matching RA[i] (nonzero address).
  - RBUSY[i] = 0 when such a write is present, unless a same-cycle reserve also targets RA[i].
  - This gives write-then-read in one cycle, matching the existing core's forwarding.
- Undefined: reads and RBUSY reflect registered state only; the new value is visible the cycle after the write.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW/NREG/NRD/NWR/NRSV constants;
  - the zero-register index constant;
  - a function for flattened-port slicing.
- One natural sub-module, regfile_read_port: a single read mux plus the bypass priority chain plus RBUSY generation, instantiated NRD times by generate.
- The storage array and scoreboard stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse RST mid-cycle. Required: RD for r5 = 0 immediately; RBUSY = 0; after release r5 still reads 0.
- Write/read all ports: write r1=0x11 (port0) and r2=0x22 (port1) in one cycle. Required next cycle: all 8 read ports return the correct value for their address; a write to r0 reads back 0.
- Conflict: port0 writes r7=0xAAAA and port1 writes r7=0x5555 in the same cycle. Required: r7 reads 0x5555 next cycle, and also during the write cycle under REGFILE_BYPASS_EN.
- Scoreboard: reserve r9, then 3 cycles later write r9=0x99. Required: RBUSY for r9 = 1 for cycles 1-3; data 0x99 and RBUSY 0 after the write edge.
- Reserve vs write same cycle: r4 busy; write r4=0x44 and reserve r4 simultaneously. Required: r4 data = 0x44 and RBUSY stays 1. Separately, reserve r0: RBUSY for r0 is always 0.
- Bypass on/off: write r3=0x1234 while reading r3 in the same cycle. Required: RD = 0x1234 in that cycle with REGFILE_BYPASS_EN; the old value without it, then 0x1234 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, zero-register index and flattened-port slicing helper
package regfile_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD = 8;
  localparam int DEF_NWR = 2;
  localparam int DEF_NRSV = 2;
  localparam int ZERO_REG = 0;
  function automatic int flat_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read mux with busy lookup; same-cycle write bypass under REGFILE_BYPASS_EN
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NWR = DEF_NWR,
  parameter int NRSV = DEF_NRSV,
  parameter int AW = $clog2(NREG)
) (
  input  logic                      rst_i,
  input  logic [AW-1:0]             ra_i,
  input  logic [NREG-1:0][DW-1:0]   regs_i,
  input  logic [NREG-1:0]           busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic [NWR-1:0]            we_i,
  input  logic [NWR*AW-1:0]         wa_i,
  input  logic [NWR*DW-1:0]         wd_i,
  input  logic [NRSV-1:0]           rsv_en_i,
  input  logic [NRSV*AW-1:0]        rsv_a_i,
`endif
  output logic [DW-1:0]             rd_o,
  output logic                      rbusy_o
);
  logic [DW-1:0] data;
  logic          bsy;
`ifdef REGFILE_BYPASS_EN
  logic          wr_hit;
  logic          rsv_hit;
`endif
  always_comb begin
    data = regs_i[ra_i];
    bsy = busy_i[ra_i];
`ifdef REGFILE_BYPASS_EN
    wr_hit = 1'b0;
    rsv_hit = 1'b0;
    // ascending scan lets the highest-index matching write port win
    for (int j = 0; j < NWR; j++)
      if (we_i[j] && wa_i[flat_lo(j, AW) +: AW] == ra_i) begin
        data = wd_i[flat_lo(j, DW) +: DW];
        wr_hit = 1'b1;
      end
    for (int k = 0; k < NRSV; k++)
      if (rsv_en_i[k] && rsv_a_i[flat_lo(k, AW) +: AW] == ra_i) rsv_hit = 1'b1;
    bsy = (wr_hit && !rsv_hit) ? 1'b0 : bsy;
`endif
    rd_o = (rst_i || ra_i == AW'(ZERO_REG)) ? '0 : data;
    rbusy_o = (rst_i || ra_i == AW'(ZERO_REG)) ? 1'b0 : bsy;
  end
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: NRD-read/NWR-write register file with busy scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NRD = DEF_NRD,
  parameter int NWR = DEF_NWR,
  parameter int NRSV = DEF_NRSV,
  parameter int AW = $clog2(NREG)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NRD*AW-1:0]    RA,
  output logic [NRD*DW-1:0]    RD,
  output logic [NRD-1:0]       RBUSY,
  input  logic [NWR-1:0]       WE,
  input  logic [NWR*AW-1:0]    WA,
  input  logic [NWR*DW-1:0]    WD,
  input  logic [NRSV-1:0]      RSV_EN,
  input  logic [NRSV*AW-1:0]   RSV_A
);
  logic [NREG-1:0][DW-1:0] regs_q, regs_d;
  logic [NREG-1:0]         busy_q, busy_d;
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++)
      if (WE[j] && WA[flat_lo(j, AW) +: AW] != AW'(ZERO_REG)) begin
        regs_d[WA[flat_lo(j, AW) +: AW]] = WD[flat_lo(j, DW) +: DW];
        busy_d[WA[flat_lo(j, AW) +: AW]] = 1'b0;
      end
    // reserves applied last: a new producer supersedes the retiring one
    for (int k = 0; k < NRSV; k++)
      if (RSV_EN[k]) busy_d[RSV_A[flat_lo(k, AW) +: AW]] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  for (genvar i = 0; i < NRD; i++) begin : g_rp
    regfile_read_port #(.DW(DW), .NREG(NREG), .NWR(NWR), .NRSV(NRSV), .AW(AW)) u_rp (
      .rst_i(RST),
      .ra_i(RA[i*AW +: AW]),
      .regs_i(regs_q),
      .busy_i(busy_q),
`ifdef REGFILE_BYPASS_EN
      .we_i(WE),
      .wa_i(WA),
      .wd_i(WD),
      .rsv_en_i(RSV_EN),
      .rsv_a_i(RSV_A),
`endif
      .rd_o(RD[i*DW +: DW]),
      .rbusy_o(RBUSY[i])
    );
  end
endmodule
